b16_accumulator: RTL and testbench

Frame accumulator downstream of the 16-bit ripple adder.
- Accepts a stream of 16-bit samples over a valid/ready handshake.
- Sums exactly COUNT samples per frame by looping its running total through one `b16_adder` instance (A = accumulator, B = sample).
- Counts the adder's carry-outs so the full-precision frame total is recoverable.
- Presents one result per frame on an output valid/ready handshake.

---
 rtl/b16_pkg.sv | 12 +
 rtl/b16_adder.sv | 22 ++
 rtl/b16_accumulator.sv | 96 +++++++++
 tb/tb_b16_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/b16_pkg.sv
// Shared definitions for the b16 datapath blocks: word width and the
// accumulator's state encoding.
package b16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/b16_adder.sv
// 16-bit ripple-carry adder: S = A + B (mod 2^16), C = carry-out.
module b16_adder
    import b16_pkg::*;
(
    output logic [WORD_W-1:0] S,
    output logic              C,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B
);

    logic [WORD_W:0] carry_chain;

    assign carry_chain[0] = 1'b0;

    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_fa
        assign S[gi]               = A[gi] ^ B[gi] ^ carry_chain[gi];
        assign carry_chain[gi + 1] = (A[gi] & B[gi]) | (carry_chain[gi] & (A[gi] ^ B[gi]));
    end

    assign C = carry_chain[WORD_W];

endmodule

// File: rtl/b16_accumulator.sv
// Frame accumulator: sums COUNT 16-bit samples through one b16_adder,
// counting carry-outs so the full-precision total is recoverable.
module b16_accumulator
    import b16_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int CW    = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [CW-1:0]     out_carries,
    output logic              out_ovf
);

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] acc_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     carries_reg;
    logic [CW-1:0]     carries_next;
    logic [WORD_W-1:0] out_sum_reg;
    logic [CW-1:0]     out_carries_reg;
    logic              out_valid_reg;
    logic              out_ovf_reg;

    logic [WORD_W-1:0] add_sum;
    logic              add_carry;
    logic              accept;
    logic              last_sample;

    b16_adder u_adder (
        .S (add_sum),
        .C (add_carry),
        .A (acc_reg),
        .B (in_data)
    );

    // in_ready is a function of state and rst only, never of in_valid.
    assign in_ready     = (state_reg == ACCUM) && !rst;
    assign accept       = in_valid && in_ready;
    assign last_sample  = (cnt_reg == CW'(COUNT - 1));
    assign carries_next = carries_reg + CW'(add_carry);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && last_sample) state_next = HOLD;
            HOLD:    if (out_ready)             state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
        if (flush) state_next = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ACCUM;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            carries_reg     <= '0;
            out_valid_reg   <= 1'b0;
            out_sum_reg     <= '0;
            out_carries_reg <= '0;
            out_ovf_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next == HOLD);
            // Flush outranks both a simultaneous accept and a result handoff.
            if (flush || (state_reg == HOLD && out_ready)) begin
                acc_reg     <= '0;
                cnt_reg     <= '0;
                carries_reg <= '0;
            end else if (accept) begin
                acc_reg     <= add_sum;
                cnt_reg     <= cnt_reg + CW'(1);
                carries_reg <= carries_next;
                if (last_sample) begin
                    out_sum_reg     <= add_sum;
                    out_carries_reg <= carries_next;
                    out_ovf_reg     <= (carries_next != '0);
                end
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_sum     = out_sum_reg;
    assign out_carries = out_carries_reg;
    assign out_ovf     = out_ovf_reg;

endmodule

// File: tb/tb_b16_accumulator.sv
// Directed and randomized checks of b16_accumulator with COUNT=4 against
// an arithmetic reference (frame total = plain integer sum of samples).
module tb_b16_accumulator;

    localparam int COUNT = 4;
    localparam int CW    = $clog2(COUNT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_sum;
    logic [CW-1:0] out_carries;
    logic          out_ovf;

    int errors = 0;
    int checks = 0;

    b16_accumulator #(.COUNT(COUNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_ovf     (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample and clock it in; in_valid is left high for back-to-back use.
    task automatic push(input logic [15:0] d);
        chk("in_ready_before_push", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string tag, input int unsigned total);
        chk({tag, "_valid"},   32'(out_valid),   32'd1);
        chk({tag, "_ready"},   32'(in_ready),    32'd0);
        chk({tag, "_sum"},     32'(out_sum),     total & 32'hFFFF);
        chk({tag, "_carries"}, 32'(out_carries), total >> 16);
        chk({tag, "_ovf"},     32'(out_ovf),     32'((total >> 16) != 0));
        $display("frame %s: sum=%04h carries=%0d ovf=%0b (total %0h)",
                 tag, out_sum, out_carries, out_ovf, total);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_handoff_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic frame(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] s3);
        push(s0); push(s1); push(s2); push(s3);
        in_valid = 1'b0;
        check_result(tag, int'(s0) + int'(s1) + int'(s2) + int'(s3));
        handoff(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   32'(out_valid),   32'd0);
        chk({tag, "_sum"},     32'(out_sum),     32'd0);
        chk({tag, "_carries"}, 32'(out_carries), 32'd0);
        chk({tag, "_ovf"},     32'(out_ovf),     32'd0);
    endtask

    initial begin
        int unsigned total;
        logic [15:0] d;
        logic [15:0] held_sum;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Directed frames from the test plan
        frame("basic", 16'h0003, 16'h0004, 16'h0300, 16'h0400);
        frame("one_carry", 16'h0003, 16'hFFFF, 16'h0000, 16'h0000);
        frame("all_ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Backpressure: in_valid held high with changing data while HOLD
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        check_result("bp", 32'h0000AAAA);
        for (int i = 0; i < 5; i++) begin
            in_data = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum",   32'(out_sum),   32'h0000AAAA);
        end
        in_valid = 1'b0;
        handoff("bp");
        frame("after_bp", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

        // Flush alongside a third sample; it must be ignored
        push(16'h1000); push(16'h1000);
        in_data = 16'h1000;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush   = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        frame("after_flush", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

        // Flush during HOLD with out_ready also high drops the result
        push(16'h0005); push(16'h0006); push(16'h0007); push(16'h0008);
        in_valid  = 1'b0;
        check_result("pre_hold_flush", 32'd26);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("hold_flush_valid", 32'(out_valid), 32'd0);
        chk("hold_flush_ready", 32'(in_ready),  32'd1);

        // Reset mid-frame
        push(16'h0100); push(16'h0200);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        rst = 1'b0;
        #1;
        chk("rst_mid_ready_after", 32'(in_ready), 32'd1);
        frame("after_rst_mid", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

        // Reset during HOLD
        push(16'h8000); push(16'h8000); push(16'h0009); push(16'h0001);
        in_valid = 1'b0;
        check_result("pre_rst_hold", 32'h0001000A);
        rst = 1'b1;
        #1;
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        #1;
        frame("after_rst_hold", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

        // Randomized frames with idle gaps and delayed consumer
        for (int f = 0; f < 8; f++) begin
            total = 0;
            for (int k = 0; k < COUNT; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    @(posedge clk); #1;
                end
                d = (f < 3) ? 16'($urandom_range(16'hF000, 16'hFFFF)) : 16'($urandom);
                total += int'(d);
                push(d);
            end
            in_valid = 1'b0;
            check_result($sformatf("rand%0d", f), total);
            held_sum = out_sum;
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                @(posedge clk); #1;
                chk("rand_wait_sum", 32'(out_sum), 32'(held_sum));
            end
            handoff($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
